// File: rtl/keccak_pkg.sv
// Shared types and sizing for the Keccak-f[1600] sponge core.
// The controller FSM encoding and the rate/round geometry live here.
package keccak_pkg;

  localparam int unsigned W          = 64;
  localparam int unsigned RATE_WORDS = 17;
  localparam int unsigned N_ROUNDS   = 24;
  localparam int unsigned CNT_W      = $clog2(RATE_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ABSORB  = 3'd2,
    ROUNDS  = 3'd3,
    SQ_LOAD = 3'd4,
    DRAIN   = 3'd5,
    PERMUTE = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/keccak_controller.sv
// Sequencing FSM for the Keccak-f[1600] round datapath: header/message intake,
// 24-round permutations per block, and squeeze streaming with extra permutes.
module keccak_controller
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  input  logic last_input_data,
  input  logic last_output_data,
  input  logic round_done,
  output logic control_regs_enable,
  output logic state_clear,
  output logic input_buffer_we,
  output logic absorb_enable,
  output logic round_count_en,
  output logic state_enable,
  output logic output_buffer_load,
  output logic output_buffer_shift,
  output logic busy
);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] sq_cnt;
  logic             last_seen;
  logic             load_full;
  logic             sq_full;

  assign load_full = (load_cnt == CNT_W'(RATE_WORDS - 1));
  assign sq_full   = (sq_cnt == CNT_W'(RATE_WORDS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        if (in_valid && (load_full || last_input_data)) state_next = ABSORB;
      end
      ABSORB: begin
        state_next = ROUNDS;
      end
      ROUNDS: begin
        if (round_done) state_next = last_seen ? SQ_LOAD : LOAD;
      end
      SQ_LOAD: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_output_data) begin
            state_next = IDLE;
          end else if (sq_full) begin
            state_next = PERMUTE;
          end
        end
      end
      PERMUTE: begin
        if (round_done) state_next = SQ_LOAD;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobe decode; everything is forced low while rst is held
  always_comb begin
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    out_last            = 1'b0;
    control_regs_enable = 1'b0;
    state_clear         = 1'b0;
    input_buffer_we     = 1'b0;
    absorb_enable       = 1'b0;
    round_count_en      = 1'b0;
    state_enable        = 1'b0;
    output_buffer_load  = 1'b0;
    output_buffer_shift = 1'b0;
    busy                = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          in_ready            = 1'b1;
          control_regs_enable = in_valid;
          state_clear         = in_valid;
        end
        LOAD: begin
          in_ready        = 1'b1;
          input_buffer_we = in_valid;
        end
        ABSORB: begin
          absorb_enable  = 1'b1;
          state_enable   = 1'b1;
          round_count_en = 1'b1;
        end
        ROUNDS, PERMUTE: begin
          state_enable   = 1'b1;
          round_count_en = 1'b1;
        end
        SQ_LOAD: begin
          output_buffer_load = 1'b1;
        end
        DRAIN: begin
          out_valid           = 1'b1;
          out_last            = last_output_data;
          output_buffer_shift = out_ready;
        end
        default: begin
        end
      endcase
    end
  end

  // Block fill / squeeze word counters and end-of-message flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      sq_cnt    <= '0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) last_seen <= 1'b0;
        end
        LOAD: begin
          if (in_valid) begin
            if (load_full || last_input_data) begin
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + CNT_W'(1);
            end
            if (last_input_data) last_seen <= 1'b1;
          end
        end
        SQ_LOAD: begin
          sq_cnt <= '0;
        end
        DRAIN: begin
          if (out_ready) sq_cnt <= sq_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
